mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mriscv_pkg.sv | 36 +++
 rtl/load_align.sv | 34 +++
 rtl/mem_access.sv | 149 ++++++++++++++
 tb/tb_mem_access.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mriscv_pkg.sv
// Shared definitions for the mriscv load/store stage: func3 width codes,
// FSM state encoding, and the access legality check.
package mriscv_pkg;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns 1 when the access must fault: an unknown width code for the
  // direction, or an address not aligned to the access width.
  function automatic logic access_fault(input logic store, input logic [2:0] f3,
                                        input logic [1:0] lsb);
    logic illegal;
    logic misaligned;
    if (store) illegal = (f3 > F3_SW);
    else       illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    misaligned = ((f3[1:0] == 2'b01) && lsb[0]) ||
                 ((f3[1:0] == 2'b10) && (lsb != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction: picks the addressed byte/half from a
// 32-bit bus word and sign- or zero-extends it according to func3.
module load_align
  import mriscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] value
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  // Lane selection followed by width/sign extension
  always_comb begin
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_LB:   value = 32'(byte_sel);
      F3_LH:   value = 32'(half_sel);
      F3_LBU:  value = {24'd0, byte_sel};
      F3_LHU:  value = {16'd0, half_sel};
      F3_LW:   value = rdata;
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results straight to write-back, faults
// misaligned/illegal accesses, and runs loads/stores over a req/ack data bus.
module mem_access
  import mriscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data,
  input  logic [2:0]  func3,
  input  logic [4:0]  dest_i,
  output logic        busy,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [4:0]  dest_o,
  output logic        fault_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        is_mem;
  logic        bad;
  logic        start;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  logic [31:0] addr_q;
  logic [1:0]  lsb_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [2:0]  func3_q;
  logic [4:0]  dest_q;
  logic [31:0] load_val;

  load_align u_load_align (
    .rdata (mem_rdata),
    .addr  (lsb_q),
    .func3 (func3_q),
    .value (load_val)
  );

  // Next-state logic; IDLE and DONE both accept a new instruction
  always_comb begin
    accept  = valid_i && (state_q != REQ);
    is_mem  = is_load || is_store;
    bad     = access_fault(is_store, func3, result_i[1:0]);
    start   = accept && is_mem && !bad;
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? REQ : IDLE;
      REQ:        if (mem_ack) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Store lane placement: replicate the datum across the word, strobe its lanes
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = store_data;
    case (func3)
      F3_SB: begin
        st_strb  = 4'b0001 << result_i[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        st_strb  = result_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch; held constant for the whole REQ phase
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      lsb_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      func3_q <= '0;
      dest_q  <= '0;
    end else if (start) begin
      addr_q  <= {result_i[31:2], 2'b00};
      lsb_q   <= result_i[1:0];
      we_q    <= is_store;
      wdata_q <= is_store ? st_wdata : 32'd0;
      strb_q  <= is_store ? st_strb : 4'd0;
      func3_q <= func3;
      dest_q  <= dest_i;
    end
  end

  // Write-back and fault pulses; everything idles at zero between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en   <= 1'b0;
      wb_data <= '0;
      dest_o  <= '0;
      fault_o <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      wb_data <= '0;
      dest_o  <= '0;
      fault_o <= 1'b0;
      if (state_q == REQ && mem_ack) begin
        if (!we_q) begin
          wb_en   <= (dest_q != 5'd0);
          wb_data <= load_val;
          dest_o  <= dest_q;
        end
      end else if (accept) begin
        if (!is_mem) begin
          wb_en   <= (dest_i != 5'd0);
          wb_data <= result_i;
          dest_o  <= dest_i;
        end else if (bad) begin
          fault_o <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state_q == REQ);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_wstrb = mem_req ? strb_q : 4'd0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a queue-based scoreboard: stimulus pushes
// expected write-back/fault events and bus requests; a negedge monitor pops
// and compares them whenever the DUT presents one.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        is_load;
  logic        is_store;
  logic [31:0] result_i;
  logic [31:0] store_data;
  logic [2:0]  func3;
  logic [4:0]  dest_i;
  logic        busy;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  dest_o;
  logic        fault_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_access dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .result_i   (result_i),
    .store_data (store_data),
    .func3      (func3),
    .dest_i     (dest_i),
    .busy       (busy),
    .wb_en      (wb_en),
    .wb_data    (wb_data),
    .dest_o     (dest_o),
    .fault_o    (fault_o),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fault;
    logic [31:0] data;
    logic [4:0]  dest;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_wb(input logic f, input logic [31:0] d, input logic [4:0] r);
    wb_q.push_back('{fault: f, data: d, dest: r});
  endtask

  task automatic exp_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s);
    req_q.push_back('{we: we, addr: a, wdata: wd, strb: s});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle
  task automatic drive(input logic ld, input logic st, input logic [31:0] res,
                       input logic [31:0] sd, input logic [2:0] f3, input logic [4:0] d);
    valid_i    = 1'b1;
    is_load    = ld;
    is_store   = st;
    result_i   = res;
    store_data = sd;
    func3      = f3;
    dest_i     = d;
    step();
    valid_i  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  // Bus responder: wait (bounded) for mem_req, stall, then ack one cycle
  task automatic serve(input int waits, input logic [31:0] rd);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    if (!mem_req) chk("req_timeout", 32'(mem_req), 32'd1);
    else begin
      chk("busy_in_req", 32'(busy), 32'd1);
      repeat (waits) step();
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  // Scoreboard monitor
  req_t snap;
  logic req_seen = 1'b0;

  always @(negedge clk) begin
    wb_t  e;
    req_t r;
    if (wb_en || fault_o) begin
      chk("wb_fault_exclusive", 32'(wb_en && fault_o), 32'd0);
      if (wb_q.size() == 0) chk("unexpected_wb", 32'({wb_en, fault_o}), 32'd0);
      else begin
        e = wb_q.pop_front();
        chk("fault_o", 32'(fault_o), 32'(e.fault));
        chk("wb_en", 32'(wb_en), 32'(!e.fault));
        chk("dest_o", 32'(dest_o), 32'(e.dest));
        if (!e.fault) chk("wb_data", wb_data, e.data);
      end
    end
    if (mem_req && !req_seen) begin
      req_seen = 1'b1;
      snap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, strb: mem_wstrb};
      if (req_q.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
      else begin
        r = req_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(r.we));
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_wdata", mem_wdata, r.wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(r.strb));
      end
    end else if (mem_req) begin
      chk("req_stable_addr", mem_addr, snap.addr);
      chk("req_stable_wdata", mem_wdata, snap.wdata);
      chk("req_stable_ctl", 32'({mem_we, mem_wstrb}), 32'({snap.we, snap.strb}));
    end else begin
      req_seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; is_load = 1'b0; is_store = 1'b0;
    result_i = '0; store_data = '0; func3 = '0; dest_i = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dest_o", 32'(dest_o), 32'd0);
    chk("rst_fault_o", 32'(fault_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    step();
    reset = 1'b0;

    // Pass-through, and the x0 destination that must not write
    exp_wb(1'b0, 32'h1234, 5'd7);
    drive(1'b0, 1'b0, 32'h1234, 32'h0, 3'b000, 5'd7);
    @(negedge clk);
    chk("pt_mem_req", 32'(mem_req), 32'd0);
    chk("pt_busy", 32'(busy), 32'd0);
    step();
    drive(1'b0, 1'b0, 32'h55, 32'h0, 3'b000, 5'd0);
    @(negedge clk);
    chk("pt_x0_wb_en", 32'(wb_en), 32'd0);
    step();

    // LB / LBU at 0x103 with two wait states
    exp_req(1'b0, 32'h100, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'hFFFF_FF80, 5'd5);
    drive(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 5'd5);
    serve(2, 32'h80FF_FFFF);
    exp_req(1'b0, 32'h100, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'h0000_0080, 5'd6);
    drive(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 5'd6);
    serve(2, 32'h80FF_FFFF);

    // SH at 0x202: upper half strobes, no write-back
    exp_req(1'b1, 32'h200, 32'hABCD_ABCD, 4'b1100);
    drive(1'b0, 1'b1, 32'h202, 32'h0000_ABCD, 3'b001, 5'd4);
    serve(0, 32'h0);
    @(negedge clk);
    chk("sh_done_wb_en", 32'(wb_en), 32'd0);
    chk("sh_done_dest", 32'(dest_o), 32'd0);
    chk("sh_done_busy", 32'(busy), 32'd0);
    step();

    // Misaligned LW: one-cycle fault, no bus request
    exp_wb(1'b1, 32'h0, 5'd0);
    drive(1'b1, 1'b0, 32'h301, 32'h0, 3'b010, 5'd8);
    @(negedge clk);
    chk("lw_mis_fault", 32'(fault_o), 32'd1);
    chk("lw_mis_req", 32'(mem_req), 32'd0);
    step();
    @(negedge clk);
    chk("lw_mis_fault_pulse", 32'(fault_o), 32'd0);
    chk("lw_mis_req2", 32'(mem_req), 32'd0);
    step();

    // Other load widths and lanes
    exp_req(1'b0, 32'h100, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'hFFFF_8001, 5'd9);
    drive(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 5'd9);
    serve(1, 32'h8001_7FFF);
    exp_req(1'b0, 32'h100, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'h0000_8765, 5'd10);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b101, 5'd10);
    serve(0, 32'h1234_8765);
    exp_req(1'b0, 32'h104, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'hDEAD_BEEF, 5'd11);
    drive(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 5'd11);
    serve(3, 32'hDEAD_BEEF);

    // SB lane 1 and SW
    exp_req(1'b1, 32'h300, 32'h5A5A_5A5A, 4'b0010);
    drive(1'b0, 1'b1, 32'h301, 32'h1234_565A, 3'b000, 5'd2);
    serve(0, 32'h0);
    exp_req(1'b1, 32'h400, 32'hCAFE_F00D, 4'b1111);
    drive(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 3'b010, 5'd3);
    serve(1, 32'h0);
    step();

    // Illegal codes and misaligned halves
    exp_wb(1'b1, 32'h0, 5'd0);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 3'b011, 5'd1);
    exp_wb(1'b1, 32'h0, 5'd0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 3'b110, 5'd1);
    exp_wb(1'b1, 32'h0, 5'd0);
    drive(1'b0, 1'b1, 32'h201, 32'h0, 3'b001, 5'd1);
    exp_wb(1'b1, 32'h0, 5'd0);
    drive(1'b1, 1'b0, 32'h103, 32'h0, 3'b101, 5'd1);
    step();

    // Back-to-back: pass-through accepted in the DONE cycle
    exp_req(1'b0, 32'h700, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'h0102_0304, 5'd14);
    exp_wb(1'b0, 32'h0000_0099, 5'd15);
    drive(1'b1, 1'b0, 32'h700, 32'h0, 3'b010, 5'd14);
    serve(1, 32'h0102_0304);
    drive(1'b0, 1'b0, 32'h99, 32'h0, 3'b000, 5'd15);
    @(negedge clk);
    chk("b2b_wb_en", 32'(wb_en), 32'd1);
    step();

    // Inputs presented while busy are ignored
    exp_req(1'b0, 32'h600, 32'h0, 4'b0000);
    exp_wb(1'b0, 32'h1111_2222, 5'd13);
    drive(1'b1, 1'b0, 32'h600, 32'h0, 3'b010, 5'd13);
    valid_i = 1'b1; result_i = 32'h77; dest_i = 5'd3;
    step();
    step();
    valid_i = 1'b0;
    serve(0, 32'h1111_2222);
    step();

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_busy", 32'(busy), 32'd0);
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    chk("stray_ack_wb", 32'(wb_en), 32'd0);
    step();

    // Reset in the middle of a request abandons it
    exp_req(1'b0, 32'h500, 32'h0, 4'b0000);
    drive(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 5'd12);
    @(negedge clk);
    chk("mid_rst_req_before", 32'(mem_req), 32'd1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_req_after", 32'(mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wb", 32'(wb_en), 32'd0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("mid_rst_no_wb", 32'(wb_en), 32'd0);

    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
